// File: rtl/voice_mix_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : voice_mix_scheduler
//  Description : Time-multiplexed voice mixer. Snapshots one sample per voice,
//                applies a per-voice gain through one shared signed multiplier
//                (one voice per cycle), saturates the sum to SAMPLE_W bits and
//                emits it with a one-cycle valid pulse. Gains are stepped by
//                keypad pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module voice_mix_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_valid,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic                           gain_step,
    input  logic [1:0]                     gain_sel,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [NUM_VOICES*GAIN_W-1:0]   gains
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_VOICES) + 2;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_VOICES - 1);
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(8);

    // Saturation limits expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic mac_en;
    logic out_en;

    logic signed [SAMPLE_W-1:0] snap_s [NUM_VOICES];
    logic        [GAIN_W-1:0]   snap_g [NUM_VOICES];
    logic        [GAIN_W-1:0]   gain   [NUM_VOICES];

    logic        [IDX_W-1:0]    idx;
    logic signed [ACC_W-1:0]    acc;

    logic signed [SAMPLE_W-1:0] mul_a;
    logic        [GAIN_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [SAMPLE_W-1:0] sat_val;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mac_en     = 1'b0;
        out_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_valid) begin
                    accept     = 1'b1;
                    next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                out_en     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shared multiplier: gain is zero-extended so it multiplies as unsigned
    assign mul_a       = snap_s[idx];
    assign mul_b       = snap_g[idx];
    assign product     = mul_a * $signed({1'b0, mul_b});
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign shifted     = acc >>> 3;

    // Clamp the scaled sum into the output sample range
    always_comb begin
        sat_val = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_W-1:0];
        end
    end

    // Snapshot of samples and gains taken at the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap_s[i] <= '0;
                snap_g[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap_s[i] <= $signed(voice_samples[i*SAMPLE_W +: SAMPLE_W]);
                snap_g[i] <= gain[i];
            end
        end
    end

    // Accumulator, voice counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= out_en;
            overrun   <= sample_valid & busy;
            if (accept) begin
                acc  <= '0;
                idx  <= '0;
                busy <= 1'b1;
            end
            if (mac_en) begin
                acc <= acc + product_ext;
                idx <= idx + 1'b1;
            end
            if (out_en) begin
                mix_out <= sat_val;
                busy    <= 1'b0;
            end
        end
    end

    // Per-voice gain registers, stepped with wrap-around
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_gain
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                gain[i] <= GAIN_UNITY;
            end else if (gain_step && (32'(gain_sel) == i)) begin
                gain[i] <= gain[i] + 1'b1;
            end
        end
        assign gains[i*GAIN_W +: GAIN_W] = gain[i];
    end

endmodule
`default_nettype wire
